// File: rtl/unit_reg_bank_pkg.sv
// Shared register offsets, bit positions and handshake state type for the unit register bank.
package unit_reg_bank_pkg;

    localparam int REG_CONTROL      = 0;
    localparam int REG_STATUS       = 1;
    localparam int REG_SCRATCH      = 2;
    localparam int REG_TIMER_COUNT  = 3;
    localparam int REG_TIMER_RELOAD = 4;
    localparam int REG_VERSION      = 5;

    localparam int CTRL_TIMER_EN_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT   = 1;
    localparam int STATUS_WRAP_BIT   = 0;

    typedef enum logic {
        HS_IDLE   = 1'b0,
        HS_SERVED = 1'b1
    } hs_state_e;

endpackage

// File: rtl/unit_timer.sv
// Count-down reload timer: loads on enable, decrements while enabled, reloads and pulses wrap at zero.
module unit_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] reload_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap;

    always_comb begin
        count_d = count_q;
        wrap    = 1'b0;
        if (load_i) begin
            count_d = reload_i;
        end else if (en_i) begin
            if (count_q == '0) begin
                count_d = reload_i;
                wrap    = 1'b1;
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap;

endmodule

// File: rtl/unit_reg_bank.sv
// Register bank behind the AXI-Lite slave's unit interface: one-pulse write/read handshakes,
// control/scratch/W1C status/timer registers, and a registered interrupt.
module unit_reg_bank
    import unit_reg_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 16,
    parameter logic [DATA_WIDTH-1:0] VERSION        = 32'h0001_0000,
    parameter logic [DATA_WIDTH-1:0] RELOAD_DEFAULT = 32'hFFFF
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  unit_wen,
    input  logic [ADDR_WIDTH-1:0] unit_waddr,
    input  logic [DATA_WIDTH-1:0] unit_wdata,
    output logic                  unit_wack,
    output logic                  unit_invalid_waddr,
    input  logic                  unit_ren,
    input  logic [ADDR_WIDTH-1:0] unit_raddr,
    output logic [DATA_WIDTH-1:0] unit_rdata,
    output logic                  unit_rstrb,
    output logic                  unit_invalid_raddr,
    output logic                  irq
);

    hs_state_e             wState_q, wState_d;
    hs_state_e             rState_q, rState_d;
    logic                  wFire, rFire;

    logic                  wack_q, wInvalid_q;
    logic                  rstrb_q, rInvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  irq_q;

    logic [1:0]            control_q, control_d;
    logic                  status_q, status_d;
    logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
    logic [DATA_WIDTH-1:0] reload_q, reload_d;

    logic                  wWritable;
    logic                  selCtrl, selStatus, selScratch, selReload;
    logic                  rMapped;
    logic [DATA_WIDTH-1:0] rValue;

    logic                  timerLoad, timerWrap;
    logic [DATA_WIDTH-1:0] timerCount;

    // A request is served once; the channel re-arms only after the request drops.
    always_comb begin
        wState_d = wState_q;
        wFire    = 1'b0;
        case (wState_q)
            HS_IDLE: begin
                if (unit_wen) begin
                    wFire    = 1'b1;
                    wState_d = HS_SERVED;
                end
            end
            HS_SERVED: begin
                if (!unit_wen) wState_d = HS_IDLE;
            end
            default: wState_d = HS_IDLE;
        endcase
    end

    always_comb begin
        rState_d = rState_q;
        rFire    = 1'b0;
        case (rState_q)
            HS_IDLE: begin
                if (unit_ren) begin
                    rFire    = 1'b1;
                    rState_d = HS_SERVED;
                end
            end
            HS_SERVED: begin
                if (!unit_ren) rState_d = HS_IDLE;
            end
            default: rState_d = HS_IDLE;
        endcase
    end

    always_comb begin
        wWritable  = 1'b0;
        selCtrl    = 1'b0;
        selStatus  = 1'b0;
        selScratch = 1'b0;
        selReload  = 1'b0;
        case (unit_waddr)
            ADDR_WIDTH'(REG_CONTROL): begin
                wWritable = 1'b1;
                selCtrl   = wFire;
            end
            ADDR_WIDTH'(REG_STATUS): begin
                wWritable = 1'b1;
                selStatus = wFire;
            end
            ADDR_WIDTH'(REG_SCRATCH): begin
                wWritable  = 1'b1;
                selScratch = wFire;
            end
            ADDR_WIDTH'(REG_TIMER_RELOAD): begin
                wWritable = 1'b1;
                selReload = wFire;
            end
            default: wWritable = 1'b0;
        endcase
    end

    // Timer wrap is applied after the W1C clear so a same-edge wrap keeps the flag set.
    always_comb begin
        control_d = control_q;
        scratch_d = scratch_q;
        reload_d  = reload_q;
        status_d  = status_q;
        if (selCtrl)    control_d = unit_wdata[1:0];
        if (selScratch) scratch_d = unit_wdata;
        if (selReload)  reload_d  = unit_wdata;
        if (selStatus && unit_wdata[STATUS_WRAP_BIT]) status_d = 1'b0;
        if (timerWrap)  status_d  = 1'b1;
        timerLoad = selCtrl && unit_wdata[CTRL_TIMER_EN_BIT] && !control_q[CTRL_TIMER_EN_BIT];
    end

    always_comb begin
        rMapped = 1'b1;
        rValue  = '0;
        case (unit_raddr)
            ADDR_WIDTH'(REG_CONTROL):      rValue = DATA_WIDTH'(control_q);
            ADDR_WIDTH'(REG_STATUS):       rValue = DATA_WIDTH'(status_q);
            ADDR_WIDTH'(REG_SCRATCH):      rValue = scratch_q;
            ADDR_WIDTH'(REG_TIMER_COUNT):  rValue = timerCount;
            ADDR_WIDTH'(REG_TIMER_RELOAD): rValue = reload_q;
            ADDR_WIDTH'(REG_VERSION):      rValue = VERSION;
            default:                       rMapped = 1'b0;
        endcase
        rdata_d = (rFire && rMapped) ? rValue : '0;
    end

    unit_timer #(
        .WIDTH (DATA_WIDTH)
    ) u_timer (
        .clk_i    (s_axi_aclk),
        .rst_ni   (s_axi_aresetn),
        .en_i     (control_q[CTRL_TIMER_EN_BIT]),
        .load_i   (timerLoad),
        .reload_i (reload_q),
        .count_o  (timerCount),
        .wrap_o   (timerWrap)
    );

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wState_q   <= HS_IDLE;
            rState_q   <= HS_IDLE;
            wack_q     <= 1'b0;
            wInvalid_q <= 1'b0;
            rstrb_q    <= 1'b0;
            rInvalid_q <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
            control_q  <= '0;
            status_q   <= 1'b0;
            scratch_q  <= '0;
            reload_q   <= RELOAD_DEFAULT;
        end else begin
            wState_q   <= wState_d;
            rState_q   <= rState_d;
            wack_q     <= wFire;
            wInvalid_q <= wFire && !wWritable;
            rstrb_q    <= rFire;
            rInvalid_q <= rFire && !rMapped;
            rdata_q    <= rdata_d;
            irq_q      <= status_q && control_q[CTRL_IRQ_EN_BIT];
            control_q  <= control_d;
            status_q   <= status_d;
            scratch_q  <= scratch_d;
            reload_q   <= reload_d;
        end
    end

    assign unit_wack          = wack_q;
    assign unit_invalid_waddr = wInvalid_q;
    assign unit_rstrb         = rstrb_q;
    assign unit_invalid_raddr = rInvalid_q;
    assign unit_rdata         = rdata_q;
    assign irq                = irq_q;

endmodule

// File: tb/tb_unit_reg_bank.sv
// Self-checking bench for unit_reg_bank: directed scenarios plus randomized traffic
// compared every cycle against a register-array reference model.
module tb_unit_reg_bank;

    logic        clock;
    logic        reset;
    logic        unitWen;
    logic [15:0] unitWaddr;
    logic [31:0] unitWdata;
    logic        unitRen;
    logic [15:0] unitRaddr;
    logic        unit_wack, unit_invalid_waddr, unit_rstrb, unit_invalid_raddr, irqOut;
    logic [31:0] unit_rdata;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model: registers indexed by word address, plus expected outputs.
    logic [31:0] mRegs [6];
    bit          mWServed, mRServed;
    bit          eWack, eWInv, eRstrb, eRInv, eIrq;
    logic [31:0] eRdata;

    bit          wAcked, rAcked;
    int          wHold, rHold;

    unit_reg_bank dut (
        .s_axi_aclk         (clock),
        .s_axi_aresetn      (!reset),
        .unit_wen           (unitWen),
        .unit_waddr         (unitWaddr),
        .unit_wdata         (unitWdata),
        .unit_wack          (unit_wack),
        .unit_invalid_waddr (unit_invalid_waddr),
        .unit_ren           (unitRen),
        .unit_raddr         (unitRaddr),
        .unit_rdata         (unit_rdata),
        .unit_rstrb         (unit_rstrb),
        .unit_invalid_raddr (unit_invalid_raddr),
        .irq                (irqOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mRegs[0] = 32'd0;
        mRegs[1] = 32'd0;
        mRegs[2] = 32'd0;
        mRegs[3] = 32'd0;
        mRegs[4] = 32'h0000_FFFF;
        mRegs[5] = 32'h0001_0000;
        mWServed = 1'b0;
        mRServed = 1'b0;
        eWack  = 1'b0;
        eWInv  = 1'b0;
        eRstrb = 1'b0;
        eRInv  = 1'b0;
        eIrq   = 1'b0;
        eRdata = 32'd0;
    endtask

    // Applies one clock edge of the register-map rules to the model.
    task automatic modelEdge();
        bit wServe, rServe, wrap, timerOn;
        wServe = unitWen && !mWServed;
        rServe = unitRen && !mRServed;
        eIrq   = mRegs[1][0] && mRegs[0][1];
        eWack  = wServe;
        eWInv  = wServe && !(unitWaddr inside {16'd0, 16'd1, 16'd2, 16'd4});
        eRstrb = rServe;
        eRInv  = rServe && (unitRaddr > 16'd5);
        eRdata = (rServe && unitRaddr <= 16'd5) ? mRegs[unitRaddr[2:0]] : 32'd0;

        timerOn = mRegs[0][0];
        wrap    = 1'b0;
        if (wServe && unitWaddr == 16'd0 && unitWdata[0] && !timerOn) begin
            mRegs[3] = mRegs[4];
        end else if (timerOn) begin
            if (mRegs[3] == 32'd0) begin
                mRegs[3] = mRegs[4];
                wrap     = 1'b1;
            end else begin
                mRegs[3] = mRegs[3] - 32'd1;
            end
        end

        if (wrap) mRegs[1] = 32'd1;
        else if (wServe && unitWaddr == 16'd1 && unitWdata[0]) mRegs[1] = 32'd0;

        if (wServe) begin
            if (unitWaddr == 16'd0) mRegs[0] = unitWdata & 32'd3;
            if (unitWaddr == 16'd2) mRegs[2] = unitWdata;
            if (unitWaddr == 16'd4) mRegs[4] = unitWdata;
        end

        if (wServe) mWServed = 1'b1;
        else if (!unitWen) mWServed = 1'b0;
        if (rServe) mRServed = 1'b1;
        else if (!unitRen) mRServed = 1'b0;
    endtask

    task automatic checkAll();
        checkOutput("wack", unit_wack, eWack);
        checkOutput("invalid_waddr", unit_invalid_waddr, eWInv);
        checkOutput("rstrb", unit_rstrb, eRstrb);
        checkOutput("invalid_raddr", unit_invalid_raddr, eRInv);
        checkOutput("rdata", unit_rdata, eRdata);
        checkOutput("irq", irqOut, eIrq);
    endtask

    task automatic stepCycle();
        @(posedge clock);
        if (!reset) modelEdge();
        #1;
        checkAll();
    endtask

    task automatic doWrite(input logic [15:0] a, input logic [31:0] d, output logic ack, output logic inv);
        unitWen   = 1'b1;
        unitWaddr = a;
        unitWdata = d;
        stepCycle();
        ack = unit_wack;
        inv = unit_invalid_waddr;
        unitWen = 1'b0;
        stepCycle();
    endtask

    task automatic doRead(input logic [15:0] a, output logic strb, output logic inv, output logic [31:0] data);
        unitRen   = 1'b1;
        unitRaddr = a;
        stepCycle();
        strb = unit_rstrb;
        inv  = unit_invalid_raddr;
        data = unit_rdata;
        unitRen = 1'b0;
        stepCycle();
    endtask

    function automatic logic [15:0] randAddr();
        if ($urandom_range(0, 15) == 0) return 16'h0100;
        return 16'($urandom_range(0, 7));
    endfunction

    // Slave-like random driver: a request holds until acknowledged, then drops after a random hold.
    task automatic applyStimulus();
        if (unitWen) begin
            if (unit_wack) wAcked = 1'b1;
            if (wAcked) begin
                if (wHold > 0) wHold--;
                else begin
                    unitWen = 1'b0;
                    wAcked  = 1'b0;
                end
            end
        end else if ($urandom_range(0, 2) == 0) begin
            unitWen   = 1'b1;
            unitWaddr = randAddr();
            case (unitWaddr)
                16'd1:   unitWdata = 32'($urandom_range(0, 1));
                16'd4:   unitWdata = 32'($urandom_range(0, 12));
                default: unitWdata = $urandom;
            endcase
            wHold = $urandom_range(0, 2);
        end
        if (unitRen) begin
            if (unit_rstrb) rAcked = 1'b1;
            if (rAcked) begin
                if (rHold > 0) rHold--;
                else begin
                    unitRen = 1'b0;
                    rAcked  = 1'b0;
                end
            end
        end else if ($urandom_range(0, 2) == 0) begin
            unitRen   = 1'b1;
            unitRaddr = randAddr();
            rHold     = $urandom_range(0, 2);
        end
    endtask

    initial begin
        logic        ack, inv, strb;
        logic [31:0] data;

        unitWen = 1'b0; unitWaddr = 16'd0; unitWdata = 32'd0;
        unitRen = 1'b0; unitRaddr = 16'd0;
        wAcked = 1'b0; rAcked = 1'b0; wHold = 0; rHold = 0;
        reset = 1'b1;
        modelReset();
        #1;
        checkAll();
        stepCycle();
        stepCycle();
        reset = 1'b0;
        stepCycle();

        doWrite(16'd2, 32'hDEADBEEF, ack, inv);
        checkOutput("scratch write ack", 32'(ack), 32'd1);
        checkOutput("scratch write invalid", 32'(inv), 32'd0);
        doRead(16'd2, strb, inv, data);
        checkOutput("scratch read strobe", 32'(strb), 32'd1);
        checkOutput("scratch read data", data, 32'hDEADBEEF);

        unitWen = 1'b1; unitWaddr = 16'd2; unitWdata = 32'h0000_1234;
        stepCycle();
        checkOutput("held wen first wack", 32'(unit_wack), 32'd1);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("held wen no second wack", 32'(unit_wack), 32'd0);
        end
        unitWen = 1'b0;
        stepCycle();

        doRead(16'd7, strb, inv, data);
        checkOutput("unmapped read strobe", 32'(strb), 32'd1);
        checkOutput("unmapped read invalid", 32'(inv), 32'd1);
        checkOutput("unmapped read data", data, 32'd0);
        doWrite(16'd3, 32'h55, ack, inv);
        checkOutput("ro write ack", 32'(ack), 32'd1);
        checkOutput("ro write invalid", 32'(inv), 32'd1);
        doRead(16'd3, strb, inv, data);
        checkOutput("timer count unchanged", data, 32'd0);
        doRead(16'd5, strb, inv, data);
        checkOutput("version", data, 32'h0001_0000);

        doWrite(16'd2, 32'd9, ack, inv);
        unitWen = 1'b1; unitWaddr = 16'd2; unitWdata = 32'd5;
        unitRen = 1'b1; unitRaddr = 16'd2;
        stepCycle();
        checkOutput("same-cycle wack", 32'(unit_wack), 32'd1);
        checkOutput("same-cycle rstrb", 32'(unit_rstrb), 32'd1);
        checkOutput("same-cycle old data", unit_rdata, 32'd9);
        unitWen = 1'b0; unitRen = 1'b0;
        stepCycle();
        doRead(16'd2, strb, inv, data);
        checkOutput("scratch after same-cycle write", data, 32'd5);

        doWrite(16'd4, 32'd3, ack, inv);
        doWrite(16'd0, 32'd3, ack, inv);
        for (int i = 0; i < 3; i++) stepCycle();
        checkOutput("irq before wrap visible", 32'(irqOut), 32'd0);
        stepCycle();
        checkOutput("irq after wrap", 32'(irqOut), 32'd1);
        stepCycle();
        stepCycle();
        doWrite(16'd1, 32'd1, ack, inv);
        doRead(16'd1, strb, inv, data);
        checkOutput("w1c loses to wrap", data, 32'd1);
        doWrite(16'd0, 32'd2, ack, inv);
        doWrite(16'd1, 32'd1, ack, inv);
        checkOutput("irq falls after w1c", 32'(irqOut), 32'd0);
        doRead(16'd1, strb, inv, data);
        checkOutput("status cleared", data, 32'd0);
        doRead(16'd3, strb, inv, data);
        checkOutput("frozen count", data, 32'd3);

        doWrite(16'd4, 32'd0, ack, inv);
        doWrite(16'd0, 32'd1, ack, inv);
        doWrite(16'd1, 32'd1, ack, inv);
        doRead(16'd1, strb, inv, data);
        checkOutput("reload zero wraps every cycle", data, 32'd1);
        doWrite(16'd0, 32'd0, ack, inv);

        unitWen = 1'b1; unitWaddr = 16'd2; unitWdata = 32'hAA;
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("reset clears wack", 32'(unit_wack), 32'd0);
        unitWen = 1'b0;
        stepCycle();
        stepCycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("no wack after reset", 32'(unit_wack), 32'd0);
        end
        unitWen = 1'b1;
        stepCycle();
        #2;
        reset = 1'b1;
        modelReset();
        stepCycle();
        reset = 1'b0;
        stepCycle();
        checkOutput("held request served after reset", 32'(unit_wack), 32'd1);
        unitWen = 1'b0;
        stepCycle();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                modelReset();
                wAcked = 1'b0;
                rAcked = 1'b0;
                stepCycle();
                stepCycle();
                reset = 1'b0;
            end
            applyStimulus();
            stepCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
